// File: rtl/ram_rd_pkg.sv
// Shared types and helpers for the burst read controller.
package ram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned RD_LATENCY_MAX = 4;

    // Byte-address shift for one data word of width data_w bits.
    function automatic int unsigned byte_shift(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/ram_rd_burst_if.sv
// RAM port and output stream bundle of the burst read controller.
interface ram_rd_burst_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              o_en_ram;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [DATA_W-1:0] i_ram_data;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;

    modport master (
        output o_en_ram, o_ram_addr, o_data, o_valid,
        input  i_ram_data, i_ready
    );

    modport slave (
        input  o_en_ram, o_ram_addr, o_data, o_valid,
        output i_ram_data, i_ready
    );
endinterface

// File: rtl/ram_rd_fifo.sv
// Synchronous output FIFO with flush; head is zero while empty.
module ram_rd_fifo #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_n_reset,
    input  logic                        i_flush,
    input  logic                        i_wr,
    input  logic [DATA_W-1:0]           i_wr_data,
    input  logic                        i_rd,
    output logic [DATA_W-1:0]           o_rd_data,
    output logic                        o_valid,
    output logic [$clog2(FIFO_DEPTH):0] o_count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    assign o_valid   = (o_count != '0);
    assign o_rd_data = o_valid ? mem[rd_ptr] : '0;
    assign push      = i_wr & (o_count != FULL);
    assign pop       = i_rd & o_valid;

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else if (i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            o_count <= o_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_flush) mem[wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/ram_rd_burst.sv
// Burst read controller: issues strided RAM reads under FIFO credit, returns data on valid/ready.
// Optional per-burst stride enabled by defining RAM_RD_STRIDE_EN (otherwise increment is 1).
module ram_rd_burst
    import ram_rd_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_n_reset,
    input  logic              i_start,
    input  logic              i_term,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [LEN_W-1:0]  i_stride,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rst_ram,
    ram_rd_burst_if.master    bus
);
    localparam int unsigned SHIFT = byte_shift(DATA_W);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

    state_t                state, state_n;
    logic                  en_q, en_n;
    logic [ADDR_W-1:0]     addr_q, addr_n;
    logic [ADDR_W-1:0]     waddr_q, waddr_n;
    logic [LEN_W-1:0]      rem_q, rem_n;
    logic [RD_LATENCY-1:0] vpipe_q, vpipe_n;
    logic [CW-1:0]         fifo_count;
    logic [ADDR_W-1:0]     inc_start, inc_run;
    logic                  pop, push, credit;
    int unsigned           occ;

`ifdef RAM_RD_STRIDE_EN
    logic [LEN_W-1:0] stride_q;

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset)                  stride_q <= '0;
        else if (state == IDLE && i_start) stride_q <= i_stride;
    end

    assign inc_start = ADDR_W'(i_stride);
    assign inc_run   = ADDR_W'(stride_q);
`else
    logic unused_stride;

    assign unused_stride = ^i_stride;
    assign inc_start     = ADDR_W'(1);
    assign inc_run       = ADDR_W'(1);
`endif

    assign o_rst_ram      = ~i_n_reset;
    assign o_busy         = (state != IDLE);
    assign o_done         = (state == DONE);
    assign bus.o_en_ram   = en_q;
    assign bus.o_ram_addr = addr_q;

    // Occupancy counts the enable on the bus, words in the latency pipe and FIFO
    // contents, less the word leaving this cycle: a new enable never overflows the FIFO.
    always_comb begin
        pop     = bus.o_valid & bus.i_ready;
        push    = vpipe_q[RD_LATENCY-1] & ~i_term;
        occ     = 32'(en_q) + 32'($countones(vpipe_q)) + 32'(fifo_count) - 32'(pop);
        credit  = (occ < FIFO_DEPTH);
        vpipe_n = i_term ? '0 : RD_LATENCY'({vpipe_q, en_q});
    end

    always_comb begin
        state_n = state;
        en_n    = 1'b0;
        addr_n  = addr_q;
        waddr_n = waddr_q;
        rem_n   = rem_q;
        case (state)
            IDLE: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        state_n = ISSUE;
                        en_n    = 1'b1;
                        addr_n  = i_base_addr << SHIFT;
                        waddr_n = i_base_addr + inc_start;
                        rem_n   = i_len - LEN_W'(1);
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            ISSUE: begin
                if (rem_q == '0) begin
                    state_n = DRAIN;
                end else if (credit) begin
                    en_n    = 1'b1;
                    addr_n  = waddr_q << SHIFT;
                    waddr_n = waddr_q + inc_run;
                    rem_n   = rem_q - LEN_W'(1);
                end
            end
            DRAIN: begin
                if (vpipe_q == '0 && (fifo_count - CW'(pop)) == '0) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (i_term) begin
            state_n = IDLE;
            en_n    = 1'b0;
            addr_n  = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state   <= IDLE;
            en_q    <= 1'b0;
            addr_q  <= '0;
            waddr_q <= '0;
            rem_q   <= '0;
            vpipe_q <= '0;
        end else begin
            state   <= state_n;
            en_q    <= en_n;
            addr_q  <= addr_n;
            waddr_q <= waddr_n;
            rem_q   <= rem_n;
            vpipe_q <= vpipe_n;
        end
    end

    ram_rd_fifo #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_n_reset(i_n_reset),
        .i_flush  (i_term),
        .i_wr     (push),
        .i_wr_data(bus.i_ram_data),
        .i_rd     (bus.i_ready),
        .o_rd_data(bus.o_data),
        .o_valid  (bus.o_valid),
        .o_count  (fifo_count)
    );

endmodule

// File: tb/tb_ram_rd_burst.sv
// Self-checking bench for ram_rd_burst against an address/data list model of each burst.
module tb_ram_rd_burst;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              n_reset = 1'b0;
    logic              start = 1'b0;
    logic              term = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  len_i = '0;
    logic [LEN_W-1:0]  stride_i = '0;
    logic              busy, done, rst_ram;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] obs_addr[$];
    int          en_cyc[$];
    logic [31:0] obs_data[$];
    int          acc_cyc[$];
    int          done_cyc[$];
    int          valid_cnt;

    logic [DATA_W-1:0] rd_pipe [RD_LAT];

    ram_rd_burst_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ram_rd_burst #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .RD_LATENCY(RD_LAT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_n_reset  (n_reset),
        .i_start    (start),
        .i_term     (term),
        .i_base_addr(base_addr),
        .i_len      (len_i),
        .i_stride   (stride_i),
        .o_busy     (busy),
        .o_done     (done),
        .o_rst_ram  (rst_ram),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
    endfunction

    // RAM model: data for the address enabled at cycle E is presented at E+RD_LAT.
    always @(posedge clk) begin
        rd_pipe[0] <= bus.o_en_ram ? ram_f(bus.o_ram_addr) : 32'hDEAD_BEEF;
        for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.i_ram_data = rd_pipe[RD_LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        obs_addr.delete();
        en_cyc.delete();
        obs_data.delete();
        acc_cyc.delete();
        done_cyc.delete();
        valid_cnt = 0;
    endtask

    // Mid-cycle monitor; also checks the head holds while stalled.
    initial begin
        logic        pv, pr;
        logic [31:0] pd;
        pv = 1'b0; pr = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (n_reset) begin
                if (bus.o_en_ram) begin
                    obs_addr.push_back(bus.o_ram_addr);
                    en_cyc.push_back(cyc);
                end
                if (bus.o_valid) valid_cnt++;
                if (bus.o_valid && bus.i_ready) begin
                    obs_data.push_back(bus.o_data);
                    acc_cyc.push_back(cyc);
                end
                if (done) done_cyc.push_back(cyc);
                if (pv && !pr && bus.o_valid) check("hold_data", bus.o_data, pd);
            end
            pv = bus.o_valid & n_reset;
            pr = bus.i_ready;
            pd = bus.o_data;
        end
    end

    // mode 0: ready high; 1: ready low for 'stall' cycles then high; 2: random ready.
    task automatic run_burst(input string tag, input logic [31:0] base, input logic [15:0] len,
                             input logic [15:0] stride, input int mode, input int stall,
                             input bit b2b);
        logic [31:0] ea[$];
        logic [31:0] inc, wa;
        int          st, n;
        clear_mon();
        base_addr   = base;
        len_i       = len;
        stride_i    = stride;
        start       = 1'b1;
        bus.i_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        st = cyc;
        tick();
        start = 1'b0;
        n = 0;
        while (done_cyc.size() == 0 && n < 3000) begin
            if (mode == 1 && n == stall)
                check({tag, "_stall_en"}, obs_addr.size(), (int'(len) < int'(DEPTH)) ? int'(len) : int'(DEPTH));
            case (mode)
                0:       bus.i_ready = 1'b1;
                1:       bus.i_ready = (n >= stall);
                default: bus.i_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            n++;
        end
        check({tag, "_timeout"}, (done_cyc.size() > 0), 1'b1);
        check({tag, "_busy_after"}, busy, 1'b0);
`ifdef RAM_RD_STRIDE_EN
        inc = 32'(stride);
`else
        inc = 32'd1;
`endif
        for (int i = 0; i < int'(len); i++) begin
            wa = base + 32'(i) * inc;
            ea.push_back(wa << 2);
        end
        check({tag, "_n_addr"}, obs_addr.size(), ea.size());
        check({tag, "_n_data"}, obs_data.size(), ea.size());
        for (int i = 0; i < ea.size(); i++) begin
            if (i < obs_addr.size()) check($sformatf("%s_addr%0d", tag, i), obs_addr[i], ea[i]);
            if (i < obs_data.size()) check($sformatf("%s_data%0d", tag, i), obs_data[i], ram_f(ea[i]));
            if (b2b && i < en_cyc.size()) check($sformatf("%s_b2b%0d", tag, i), en_cyc[i], en_cyc[0] + i);
        end
        if (done_cyc.size() > 0) begin
            if (len != 0) begin
                check({tag, "_first_en"}, (en_cyc.size() > 0) ? en_cyc[0] : -1, st + 1);
                check({tag, "_done_cyc"}, done_cyc[0], (acc_cyc.size() > 0) ? acc_cyc[$] + 1 : -1);
            end else begin
                check({tag, "_done_cyc"}, done_cyc[0], st + 1);
                check({tag, "_valid_seen"}, valid_cnt, 0);
            end
        end
        tick();
        check({tag, "_done_once"}, done_cyc.size(), 1);
    endtask

    initial begin
        logic [31:0] rb;
        int          n;
        bus.i_ready = 1'b0;

        // Reset values
        tick(); tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_en", bus.o_en_ram, 1'b0);
        check("rst_addr", bus.o_ram_addr, 32'd0);
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_data", bus.o_data, 32'd0);
        check("rst_ram_rst", rst_ram, 1'b1);
        n_reset = 1'b1;
        tick();
        check("run_ram_rst", rst_ram, 1'b0);

        // Basic burst, addresses 20,24,28,32 back to back
        run_burst("basic", 32'd5, 16'd4, 16'd1, 0, 0, 1'b1);
        // Backpressure: ready low for 10 cycles
        run_burst("stall", 32'd5, 16'd8, 16'd1, 1, 10, 1'b0);
        // Zero length
        run_burst("len0", 32'd77, 16'd0, 16'd1, 0, 0, 1'b0);
        // Address wrap (stride 3 gives word addresses ..FE, 1, 4)
        run_burst("wrap", 32'hFFFF_FFFE, 16'd3, 16'd3, 0, 0, 1'b1);
        run_burst("stride0", 32'd40, 16'd3, 16'd0, 2, 0, 1'b0);

        // Abort two cycles into an 8-word burst
        clear_mon();
        base_addr = 32'd100; len_i = 16'd8; stride_i = 16'd1;
        start = 1'b1; bus.i_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        term = 1'b1;
        tick();
        term = 1'b0;
        check("term_busy", busy, 1'b0);
        check("term_valid", bus.o_valid, 1'b0);
        check("term_en", bus.o_en_ram, 1'b0);
        check("term_addr", bus.o_ram_addr, 32'd0);
        bus.i_ready = 1'b1;
        repeat (8) tick();
        check("term_no_done", done_cyc.size(), 0);
        check("term_no_valid", valid_cnt, 0);
        run_burst("after_term", 32'd300, 16'd5, 16'd2, 0, 0, 1'b1);

        // start and term together in IDLE
        clear_mon();
        start = 1'b1; term = 1'b1;
        tick();
        start = 1'b0; term = 1'b0;
        check("st_term_busy", busy, 1'b0);
        repeat (4) tick();
        check("st_term_no_en", obs_addr.size(), 0);
        check("st_term_no_done", done_cyc.size(), 0);

        // Randomised bursts
        for (int k = 0; k < 6; k++) begin
            rb = $urandom;
            run_burst($sformatf("rnd%0d", k), rb, 16'($urandom_range(1, 12)),
                      16'($urandom_range(0, 5)), 2, 0, 1'b0);
        end

        // Asynchronous reset during DRAIN
        clear_mon();
        base_addr = 32'd900; len_i = 16'd6; stride_i = 16'd1;
        start = 1'b1; bus.i_ready = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (obs_addr.size() < 6 && n < 100) begin
            tick();
            n++;
        end
        bus.i_ready = 1'b0;
        tick(); tick(); tick();
        check("drain_busy", busy, 1'b1);
        check("drain_valid", bus.o_valid, 1'b1);
        #2;
        n_reset = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_en", bus.o_en_ram, 1'b0);
        check("arst_addr", bus.o_ram_addr, 32'd0);
        check("arst_valid", bus.o_valid, 1'b0);
        check("arst_data", bus.o_data, 32'd0);
        check("arst_ram_rst", rst_ram, 1'b1);
        tick();
        n_reset = 1'b1;
        tick();
        run_burst("post_rst", 32'd12, 16'd3, 16'd1, 0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_rd_burst.md
# ram_rd_burst

Parametrised burst read controller for the NPU's block-RAM ports; successor to the single-word RAM read front end. Given a base word address, a length and an optional stride, it issues back-to-back RAM reads and tracks the configurable RAM read latency. It returns data through a small FIFO on a valid/ready stream, so downstream compute can apply backpressure without losing words. It sits between the NPU sequencer and each BRAM port.

## Interface
- DATA_W, 32: RAM data width; must be a power of two, ≥ 8.
- ADDR_W, 32: RAM byte-address width.
- LEN_W, 16: width of burst length and stride.
- RD_LATENCY, 1: RAM enable-to-data latency in cycles; range 1..4.
- FIFO_DEPTH, 4: output FIFO depth; power of two, ≥ RD_LATENCY+1.
- i_clk  in  1  clock; all logic on its rising edge.
- i_n_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  burst request; sampled only in IDLE.
- i_term  in  1  abort; takes priority over everything except reset.
- i_base_addr  in  ADDR_W  first word address (word units).
- i_len  in  LEN_W  number of words to read; 0 is legal.
- i_stride  in  LEN_W  word-address increment; used only with the stride feature (see Configuration).
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when a burst completes normally.
- o_rst_ram  out  1  = ~i_n_reset, combinational.
- o_en_ram  out  1  registered RAM enable.
- o_ram_addr  out  ADDR_W  registered byte address = word address << log2(DATA_W/8).
- i_ram_data  in  DATA_W  RAM read data.
- o_data  out  DATA_W  FIFO head.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  consumer accepts o_data when o_valid & i_ready.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on i_start, latch base, len and stride. Go to ISSUE if len ≠ 0, else go to DONE.
- ISSUE: each cycle in which credit is available:
  - o_en_ram = 1;
  - o_ram_addr = word_addr shifted;
  - word_addr += stride, mod 2^ADDR_W word space, wraps silently;
  - remaining −= 1.
- Credit condition: in_flight + fifo_count < FIFO_DEPTH. Otherwise o_en_ram = 0 and the address holds.
- ISSUE → DRAIN in the cycle after the last read is issued.
- Valid pipeline: a shift register of RD_LATENCY stages tracks each enable. When the tail is set, i_ram_data is written into the FIFO.
- DRAIN → DONE when in_flight = 0 and the FIFO is empty, i.e. all words have been accepted.
- DONE: o_done = 1 for one cycle, then IDLE. i_start is ignored outside IDLE.
- i_term in any state:
  - next state IDLE;
  - pipeline cleared and FIFO flushed (in-flight data discarded);
  - o_en_ram = 0, address = 0;
  - no o_done pulse.
- i_start and i_term asserted together in IDLE: i_term wins; no burst starts.
- Reset values: state IDLE, o_busy 0, o_done 0, o_en_ram 0, o_ram_addr 0, o_valid 0, o_data 0, counters 0.
- Reset asserted mid-burst clears everything asynchronously.

## Timing
- i_start at cycle T → first o_en_ram at T+1.
- Enable at cycle E → data sampled at E+RD_LATENCY → o_valid at E+RD_LATENCY+1.
- With i_ready held high and FIFO_DEPTH ≥ RD_LATENCY+2, throughput is one word per cycle.
- The last beat accepted at cycle A → o_done at A+1 → IDLE (o_busy 0) at A+2.
- A burst of len 0 gives o_done at T+1 with no RAM enables.
- o_data is stable while o_valid & ~i_ready.

## Configuration
- RAM_RD_STRIDE_EN defined: the address increment is i_stride latched at start. Stride 0 re-reads the same word len times.
- Not defined: the increment is fixed at 1, and i_stride is unused with no stride register synthesised.

## Structure
- Package ram_rd_pkg holds:
  - the state encoding (IDLE=0, ISSUE=1, DRAIN=2, DONE=3);
  - the RD_LATENCY_MAX=4 constant;
  - the function computing the byte shift from DATA_W.
- Sub-module ram_rd_fifo: synchronous FIFO, parametrised DATA_W/FIFO_DEPTH, with flush input and count output.

## Test plan
- base=5, len=4, RD_LATENCY=1, i_ready=1 → o_ram_addr 20,24,28,32 on consecutive cycles; four beats in order; o_done once.
- Same burst with RD_LATENCY=3, i_ready low for 10 cycles → enables stall after FIFO_DEPTH outstanding; no beats lost or duplicated after i_ready rises.
- len=0 → o_done at T+1, o_en_ram never high, o_valid never high.
- i_term two cycles into an 8-word burst → IDLE next cycle, o_valid 0, no o_done; a new burst then returns only its own data.
- With RAM_RD_STRIDE_EN, base=2^ADDR_W−2 (word space), stride=3, len=3 → word addresses wrap to 1, then 4.
- Reset asserted during DRAIN → all outputs at reset values immediately, no clock required.
